// File: rtl/mlp_pkg.sv
// Constants and types shared by the 64->8->10 MLP core and its argmax back-end.
package mlp_pkg;
    localparam int OUT_DIM = 10;
    localparam int ACCW    = 32;
    localparam int IDXW    = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic signed [ACCW-1:0] MIN_LOGIT = {1'b1, {(ACCW-1){1'b0}}};

    // Sign-extend both operands so the difference cannot wrap.
    function automatic logic [ACCW:0] calc_margin(input logic signed [ACCW-1:0] best,
                                                  input logic signed [ACCW-1:0] second);
        return {best[ACCW-1], best} - {second[ACCW-1], second};
    endfunction
endpackage

// File: rtl/mlp_argmax_if.sv
// Logit-in / decision-out handshake bundle of the argmax back-end.
interface mlp_argmax_if;
    import mlp_pkg::*;

    logic                    in_valid;
    logic                    in_ready;
    logic [OUT_DIM*ACCW-1:0] logits_flat;
    logic                    out_valid;
    logic                    out_ready;
    logic [IDXW-1:0]         class_idx;
    logic [ACCW-1:0]         max_logit;
    logic [ACCW:0]           margin;

    modport master (
        output in_valid, logits_flat, out_ready,
        input  in_ready, out_valid, class_idx, max_logit, margin
    );

    modport slave (
        input  in_valid, logits_flat, out_ready,
        output in_ready, out_valid, class_idx, max_logit, margin
    );
endinterface

// File: rtl/mlp_argmax_step.sv
// One compare step of the running max / runner-up scan; ties keep the lower index.
module mlp_argmax_step
    import mlp_pkg::*;
(
    input  logic signed [ACCW-1:0] best,
    input  logic signed [ACCW-1:0] second,
    input  logic        [IDXW-1:0] idx,
    input  logic signed [ACCW-1:0] cand,
    input  logic        [IDXW-1:0] k,
    output logic signed [ACCW-1:0] best_nx,
    output logic signed [ACCW-1:0] second_nx,
    output logic        [IDXW-1:0] idx_nx
);

    // Strictly greater takes the lead; an equal value only becomes runner-up.
    always_comb begin
        best_nx   = best;
        second_nx = second;
        idx_nx    = idx;
        if (cand > best) begin
            second_nx = best;
            best_nx   = cand;
            idx_nx    = k;
        end else if (cand > second) begin
            second_nx = cand;
        end else begin
            second_nx = second;
        end
    end

endmodule

// File: rtl/mlp_argmax.sv
// Sequential argmax over OUT_DIM signed logits: one compare per cycle, reports
// winner index, winning logit and margin to the runner-up.
module mlp_argmax
    import mlp_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    mlp_argmax_if.slave  bus
);

    state_t                 state_r;
    state_t                 state_nx_s;
    logic signed [ACCW-1:0] logit_r [OUT_DIM];
    logic signed [ACCW-1:0] best_r;
    logic signed [ACCW-1:0] second_r;
    logic        [IDXW-1:0] idx_r;
    logic        [IDXW-1:0] k_r;
    logic        [IDXW-1:0] class_idx_r;
    logic signed [ACCW-1:0] max_logit_r;
    logic        [ACCW:0]   margin_r;
    logic signed [ACCW-1:0] cand_s;
    logic signed [ACCW-1:0] best_nx_s;
    logic signed [ACCW-1:0] second_nx_s;
    logic        [IDXW-1:0] idx_nx_s;
    logic                   last_s;
    logic                   in_ready_s;
    logic                   out_valid_s;

    assign cand_s = logit_r[k_r];
    assign last_s = (k_r == IDXW'(OUT_DIM - 1));

    mlp_argmax_step u_step (
        .best      (best_r),
        .second    (second_r),
        .idx       (idx_r),
        .cand      (cand_s),
        .k         (k_r),
        .best_nx   (best_nx_s),
        .second_nx (second_nx_s),
        .idx_nx    (idx_nx_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next state and handshake outputs, decoded from state only.
    always_comb begin
        state_nx_s  = state_r;
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        case (state_r)
            IDLE: begin
                in_ready_s = 1'b1;
                if (bus.in_valid) begin
                    state_nx_s = SCAN;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            SCAN: begin
                if (last_s) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = SCAN;
                end
            end
            DONE: begin
                out_valid_s = 1'b1;
                if (bus.out_ready) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = DONE;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // Logit capture, running scan state and registered result fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < OUT_DIM; i++) begin
                logit_r[i] <= '0;
            end
            best_r      <= '0;
            second_r    <= '0;
            idx_r       <= '0;
            k_r         <= '0;
            class_idx_r <= '0;
            max_logit_r <= '0;
            margin_r    <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.in_valid) begin
                        for (int i = 0; i < OUT_DIM; i++) begin
                            logit_r[i] <= bus.logits_flat[i*ACCW +: ACCW];
                        end
                        best_r   <= bus.logits_flat[ACCW-1:0];
                        second_r <= MIN_LOGIT;
                        idx_r    <= '0;
                        k_r      <= IDXW'(1);
                    end
                end
                SCAN: begin
                    best_r   <= best_nx_s;
                    second_r <= second_nx_s;
                    idx_r    <= idx_nx_s;
                    if (last_s) begin
                        k_r         <= '0;
                        class_idx_r <= idx_nx_s;
                        max_logit_r <= best_nx_s;
                        margin_r    <= calc_margin(best_nx_s, second_nx_s);
                    end else begin
                        k_r <= k_r + IDXW'(1);
                    end
                end
                default: begin
                    k_r <= k_r;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_s;
    assign bus.class_idx = class_idx_r;
    assign bus.max_logit = max_logit_r;
    assign bus.margin    = margin_r;

endmodule
